lpddr2_avl_bridge: RTL and testbench



---
 rtl/lpddr2_bridge_pkg.sv | 17 +
 rtl/lpddr2_avl_bridge_if.sv | 25 ++
 rtl/lpddr2_watchdog.sv | 23 ++
 rtl/lpddr2_avl_bridge.sv | 134 +++++++++++++
 tb/tb_lpddr2_avl_bridge.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/lpddr2_bridge_pkg.sv
// Shared types and constants for the LPDDR2 Avalon-MM single-word bridge.
package lpddr2_bridge_pkg;

  localparam int unsigned AVL_ADDR_W_DEF = 27;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam logic [31:0] TIMEOUT_FILL   = 32'hDEAD_BEEF;

  typedef enum logic [3:0] {
    ST_INIT    = 4'd0,
    ST_IDLE    = 4'd1,
    ST_WR      = 4'd2,
    ST_RD_CMD  = 4'd3,
    ST_RD_WAIT = 4'd4,
    ST_DONE    = 4'd5
  } state_e;

endpackage

// File: rtl/lpddr2_avl_bridge_if.sv
// Avalon-MM port 0 of the LPDDR2 controller, plus its init-done status.
interface lpddr2_avl_bridge_if #(
  parameter int unsigned AVL_ADDR_W = 27,
  parameter int unsigned DATA_W     = 32
);
  logic                  local_init_done;
  logic                  avl_waitrequest_n;
  logic [AVL_ADDR_W-1:0] avl_address;
  logic                  avl_readdatavalid;
  logic [DATA_W-1:0]     avl_readdata;
  logic [DATA_W-1:0]     avl_writedata;
  logic                  avl_read;
  logic                  avl_write;
  logic                  avl_burstbegin;

  modport master (
    input  local_init_done, avl_waitrequest_n, avl_readdatavalid, avl_readdata,
    output avl_address, avl_writedata, avl_read, avl_write, avl_burstbegin
  );

  modport slave (
    output local_init_done, avl_waitrequest_n, avl_readdatavalid, avl_readdata,
    input  avl_address, avl_writedata, avl_read, avl_write, avl_burstbegin
  );
endinterface

// File: rtl/lpddr2_watchdog.sv
// Read-wait watchdog: counts enabled cycles, flags the last one of TIMEOUT_CYCLES.
module lpddr2_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Expired during the TIMEOUT_CYCLES-th enabled cycle so the owner can act on that edge.
  assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (clear)               cnt <= '0;
    else if (enable && !expired)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/lpddr2_avl_bridge.sv
// CPU memory port to LPDDR2 Avalon-MM bridge, one size-1 command per request.
// Optional read watchdog enabled by defining LPDDR2_BRIDGE_TIMEOUT_EN.
module lpddr2_avl_bridge
  import lpddr2_bridge_pkg::*;
#(
  parameter int unsigned AVL_ADDR_W     = AVL_ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     in_data,
  output logic [DATA_W-1:0]     out_data,
  output logic                  done,
  output logic                  busy,
  lpddr2_avl_bridge_if.master   avl,
  output logic [3:0]            c_state,
  output logic                  timeout_err
);

  state_e                state_q, state_d;
  logic [AVL_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  latch_req, latch_wdata, capture, wd_fill;
  logic                  wd_expired;
  logic                  unused_addr_bits;

  // Bits above the word address are dropped, so the space wraps modulo 512 MiB.
  assign unused_addr_bits = ^{addr[31:AVL_ADDR_W+2], addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    latch_req   = 1'b0;
    latch_wdata = 1'b0;
    capture     = 1'b0;
    wd_fill     = 1'b0;
    // Losing init aborts whatever is in flight without a done pulse.
    if (state_q != ST_INIT && !avl.local_init_done) begin
      state_d = ST_INIT;
    end else begin
      unique case (state_q)
        ST_INIT:    if (avl.local_init_done) state_d = ST_IDLE;
        ST_IDLE: begin
          if (write_req) begin
            state_d     = ST_WR;
            latch_req   = 1'b1;
            latch_wdata = 1'b1;
          end else if (read_req) begin
            state_d   = ST_RD_CMD;
            latch_req = 1'b1;
          end
        end
        ST_WR:      if (avl.avl_waitrequest_n) state_d = ST_DONE;
        ST_RD_CMD: begin
          if (avl.avl_waitrequest_n) begin
            if (avl.avl_readdatavalid) begin
              capture = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (avl.avl_readdatavalid) begin
            capture = 1'b1;
            state_d = ST_DONE;
          end else if (wd_expired) begin
            wd_fill = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      out_data <= '0;
    end else begin
      if (latch_req)   addr_q  <= addr[AVL_ADDR_W+1:2];
      if (latch_wdata) wdata_q <= in_data;
      if (capture)      out_data <= avl.avl_readdata;
      else if (wd_fill) out_data <= DATA_W'(TIMEOUT_FILL);
    end
  end

  assign avl.avl_write      = (state_q == ST_WR);
  assign avl.avl_read       = (state_q == ST_RD_CMD);
  assign avl.avl_burstbegin = (state_q == ST_WR) || (state_q == ST_RD_CMD);
  assign avl.avl_address    = addr_q;
  assign avl.avl_writedata  = wdata_q;
  assign done               = (state_q == ST_DONE);
  assign busy               = (state_q != ST_IDLE);
  assign c_state            = state_q;

`ifdef LPDDR2_BRIDGE_TIMEOUT_EN
  logic err_q;

  lpddr2_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != ST_RD_WAIT),
    .enable  (state_q == ST_RD_WAIT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (wd_fill) err_q <= 1'b1;
  end

  assign timeout_err = err_q;
`else
  localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lpddr2_avl_bridge.sv
// Directed self-checking bench for lpddr2_avl_bridge; covers LPDDR2_BRIDGE_TIMEOUT_EN when defined.
module tb_lpddr2_avl_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_req, write_req;
  logic [31:0] addr, in_data, out_data;
  logic        done, busy, timeout_err;
  logic [3:0]  c_state;

  int n_pass  = 0;
  int n_total = 0;

  lpddr2_avl_bridge_if #(.AVL_ADDR_W(27), .DATA_W(32)) avl_bus ();

  lpddr2_avl_bridge #(
    .AVL_ADDR_W(27),
    .DATA_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .read_req    (read_req),
    .write_req   (write_req),
    .addr        (addr),
    .in_data     (in_data),
    .out_data    (out_data),
    .done        (done),
    .busy        (busy),
    .avl         (avl_bus),
    .c_state     (c_state),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; read_req = 1'b0; write_req = 1'b0; addr = '0; in_data = '0;
    avl_bus.local_init_done   = 1'b0;
    avl_bus.avl_waitrequest_n = 1'b1;
    avl_bus.avl_readdatavalid = 1'b0;
    avl_bus.avl_readdata      = '0;
    #1;
    check("rst_state", c_state, 4'd0);
    check("rst_busy", busy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_strobes", {avl_bus.avl_read, avl_bus.avl_write, avl_bus.avl_burstbegin}, 3'b000);
    check("rst_out_data", out_data, 32'h0);
    check("rst_address", avl_bus.avl_address, 27'h0);
    check("rst_wdata", avl_bus.avl_writedata, 32'h0);
    check("rst_timeout_err", timeout_err, 1'b0);
    step(); step();
    rst = 1'b0;

    // Controller still calibrating: stay in INIT.
    for (int i = 0; i < 20; i++) begin
      step();
      check("init_hold_state", c_state, 4'd0);
      check("init_hold_busy", busy, 1'b1);
    end
    avl_bus.local_init_done = 1'b1;
    step();
    check("init_to_idle", c_state, 4'd1);
    check("idle_busy", busy, 1'b0);

    // Write, controller always ready.
    write_req = 1'b1; addr = 32'h0000_0010; in_data = 32'hCAFE_0001;
    step();
    check("wr_state", c_state, 4'd2);
    check("wr_strobe", {avl_bus.avl_write, avl_bus.avl_burstbegin, avl_bus.avl_read}, 3'b110);
    check("wr_address", avl_bus.avl_address, 27'd4);
    check("wr_wdata", avl_bus.avl_writedata, 32'hCAFE_0001);
    check("wr_done_early", done, 1'b0);
    step();
    check("wr_done", done, 1'b1);
    check("wr_strobe_off", avl_bus.avl_write, 1'b0);
    write_req = 1'b0;
    step();
    check("wr_done_pulse", done, 1'b0);
    check("wr_back_idle", c_state, 4'd1);

    // Read with 5 wait cycles, data 7 cycles after acceptance.
    read_req = 1'b1; avl_bus.avl_waitrequest_n = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("rd_hold_read", {avl_bus.avl_read, avl_bus.avl_burstbegin}, 2'b11);
      check("rd_hold_addr", avl_bus.avl_address, 27'd4);
      step();
    end
    check("rd_hold_last", {c_state, avl_bus.avl_read}, {4'd3, 1'b1});
    avl_bus.avl_waitrequest_n = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      check("rd_wait_state", c_state, 4'd4);
      check("rd_wait_quiet", {avl_bus.avl_read, done}, 2'b00);
      step();
    end
    avl_bus.avl_readdatavalid = 1'b1; avl_bus.avl_readdata = 32'hCAFE_0001;
    step();
    avl_bus.avl_readdatavalid = 1'b0; avl_bus.avl_readdata = 32'hFFFF_FFFF;
    check("rd_done", done, 1'b1);
    check("rd_data", out_data, 32'hCAFE_0001);
    read_req = 1'b0;
    step();
    check("rd_done_pulse", done, 1'b0);
    check("rd_idle", c_state, 4'd1);

    // Stray readdatavalid in IDLE is ignored.
    avl_bus.avl_readdatavalid = 1'b1; avl_bus.avl_readdata = 32'h1234_5678;
    step();
    avl_bus.avl_readdatavalid = 1'b0;
    check("stray_rdv_ignored", out_data, 32'hCAFE_0001);

    // Acceptance and readdatavalid on the same edge; upper address bits dropped.
    read_req = 1'b1; addr = 32'h2000_0024;
    step();
    check("fast_rd_addr", avl_bus.avl_address, 27'd9);
    avl_bus.avl_readdatavalid = 1'b1; avl_bus.avl_readdata = 32'hA5A5_0003;
    step();
    avl_bus.avl_readdatavalid = 1'b0;
    check("fast_rd_state", c_state, 4'd5);
    check("fast_rd_data", out_data, 32'hA5A5_0003);
    read_req = 1'b0;
    step();

    // Simultaneous requests: write wins, read served afterwards only because it stays high.
    read_req = 1'b1; write_req = 1'b1; addr = 32'h0000_0040; in_data = 32'h1111_2222;
    step();
    check("both_wr_state", c_state, 4'd2);
    check("both_no_read", {avl_bus.avl_write, avl_bus.avl_read}, 2'b10);
    check("both_wr_addr", avl_bus.avl_address, 27'h10);
    step();
    check("both_wr_done", done, 1'b1);
    write_req = 1'b0;
    step();
    check("both_idle", c_state, 4'd1);
    step();
    check("both_rd_follows", {c_state, avl_bus.avl_read}, {4'd3, 1'b1});
    avl_bus.avl_readdatavalid = 1'b1; avl_bus.avl_readdata = 32'h3333_4444;
    step();
    avl_bus.avl_readdatavalid = 1'b0;
    check("both_rd_data", out_data, 32'h3333_4444);
    read_req = 1'b0;
    step();

    // Init lost while waiting for read data.
    read_req = 1'b1; addr = 32'h0000_0080;
    step(); step();
    check("abort_in_rd_wait", c_state, 4'd4);
    avl_bus.local_init_done = 1'b0;
    step();
    read_req = 1'b0;
    check("abort_state", c_state, 4'd0);
    check("abort_no_done", done, 1'b0);
    check("abort_strobes", {avl_bus.avl_read, avl_bus.avl_write, avl_bus.avl_burstbegin}, 3'b000);
    check("abort_busy", busy, 1'b1);
    check("abort_keep_data", out_data, 32'h3333_4444);
    avl_bus.avl_readdatavalid = 1'b1; avl_bus.avl_readdata = 32'h0BAD_0BAD;
    step();
    avl_bus.avl_readdatavalid = 1'b0;
    check("abort_late_rdv", out_data, 32'h3333_4444);
    check("abort_still_no_done", done, 1'b0);
    avl_bus.local_init_done = 1'b1;
    step();
    check("reinit_idle", c_state, 4'd1);

`ifdef LPDDR2_BRIDGE_TIMEOUT_EN
    read_req = 1'b1; addr = 32'h0000_0084;
    step(); step();
    for (int i = 0; i < 16; i++) begin
      check("to_wait_state", c_state, 4'd4);
      check("to_err_low", timeout_err, 1'b0);
      step();
    end
    check("to_done", done, 1'b1);
    check("to_err", timeout_err, 1'b1);
    check("to_fill", out_data, 32'hDEAD_BEEF);
    read_req = 1'b0;
    step();
    check("to_err_sticky", {c_state, timeout_err}, {4'd1, 1'b1});
`else
    read_req = 1'b1; addr = 32'h0000_0084;
    step(); step();
    for (int i = 0; i < 20; i++) begin
      check("nto_wait_state", c_state, 4'd4);
      step();
    end
    check("nto_err_low", timeout_err, 1'b0);
    avl_bus.avl_readdatavalid = 1'b1; avl_bus.avl_readdata = 32'h5555_AAAA;
    step();
    avl_bus.avl_readdatavalid = 1'b0;
    check("nto_done", done, 1'b1);
    check("nto_data", out_data, 32'h5555_AAAA);
    read_req = 1'b0;
    step();
`endif

    // Asynchronous reset in the middle of a held write.
    write_req = 1'b1; addr = 32'h0000_0100; in_data = 32'h7777_8888;
    avl_bus.avl_waitrequest_n = 1'b0;
    step();
    check("arst_pre_wr", {c_state, avl_bus.avl_write}, {4'd2, 1'b1});
    write_req = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("arst_state", c_state, 4'd0);
    check("arst_strobes", {avl_bus.avl_read, avl_bus.avl_write, avl_bus.avl_burstbegin}, 3'b000);
    check("arst_addr", avl_bus.avl_address, 27'h0);
    check("arst_wdata", avl_bus.avl_writedata, 32'h0);
    check("arst_out_data", out_data, 32'h0);
    check("arst_err", timeout_err, 1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
